// File: rtl/lsu_rdata_merge.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_rdata_merge
//  Purpose  : Return path of the LSU address split. Accepts one load request
//             at a time, collects the read word from data memory (fixed
//             1-cycle latency) or the peripheral bus (valid-qualified,
//             variable latency, optional timeout), aligns and sign/zero
//             extends the selected byte/half/word, and returns a single
//             one-cycle response pulse.
//  Ports    :
//    clk_i, rst_i            clock (rising edge), async active-high reset
//    req_valid_i/req_ready_o load request handshake
//    req_addr_i              load byte address (only [1:0] matters here)
//    req_sel_i               00/01 memory, 10 peripheral, 11 unmapped
//    req_funct3_i            000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//    mem_rdata_i             memory word, valid the cycle after accept
//    periph_req_o            held while waiting for the peripheral
//    periph_rdata_i/_valid_i peripheral word and its qualifier
//    rsp_valid_o             one-cycle response pulse
//    rsp_data_o/rsp_err_o    registered response, held between pulses
//    busy_o                  transaction in flight
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_rdata_merge #(
  parameter int ADDR_W         = 12,
  parameter int PERIPH_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_sel_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              periph_req_o,
  input  logic [31:0]       periph_rdata_i,
  input  logic              periph_valid_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_MEM_WAIT    = 2'd1;
  localparam logic [1:0] S_PERIPH_WAIT = 2'd2;
  localparam logic [1:0] S_RESP        = 2'd3;

  localparam int CNT_W = (PERIPH_TIMEOUT > 1) ? $clog2(PERIPH_TIMEOUT) : 1;
  // Value of the counter in the last permitted wait cycle. Meaningless when
  // the timeout is disabled; the compare below is gated in that case.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIPH_TIMEOUT - 1);

  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [1:0]       off_q,      off_d;
  logic [2:0]       funct3_q,   funct3_d;
  logic [1:0]       sel_q,      sel_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q,  rsp_err_d;

  logic        w_req_err;
  logic        w_timeout;
  logic [31:0] w_word;
  logic [31:0] w_ext;

  // Upper address bits only matter to the address split, not here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[ADDR_W-1:2];

  // Byte/half/word extraction from the returned word.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  o,
                                          input logic [2:0]  f3);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = w >> {o, 3'b000};
    b  = sh[7:0];
    h  = o[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};   // f3[2] selects unsigned
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Request error decode, in priority order: illegal funct3, misaligned,
  // unmapped. Only the resulting single flag matters downstream.
  always_comb begin
    w_req_err = 1'b0;
    case (req_funct3_i)
      3'b011, 3'b110, 3'b111: w_req_err = 1'b1;
      3'b001, 3'b101:         w_req_err = req_addr_i[0];
      3'b010:                 w_req_err = |req_addr_i[1:0];
      default:                w_req_err = 1'b0;
    endcase
    if (req_sel_i == 2'b11) begin
      w_req_err = 1'b1;
    end
  end

  assign w_timeout = (PERIPH_TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign w_word    = (sel_q == 2'b10) ? periph_rdata_i : mem_rdata_i;
  assign w_ext     = extract(w_word, off_q, funct3_q);

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      funct3_q   <= '0;
      sel_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
      sel_q      <= sel_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state and capture logic. The response registers are only written
  // on the transition into RESP, so they hold between pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    funct3_d   = funct3_q;
    sel_d      = sel_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid_i) begin
          off_d    = req_addr_i[1:0];
          funct3_d = req_funct3_i;
          sel_d    = req_sel_i;
          if (w_req_err) begin
            state_d    = S_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else if (req_sel_i == 2'b10) begin
            state_d = S_PERIPH_WAIT;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end
      end
      S_MEM_WAIT: begin
        state_d    = S_RESP;
        rsp_data_d = w_ext;
        rsp_err_d  = 1'b0;
      end
      S_PERIPH_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Valid data beats a timeout landing in the same cycle.
        if (periph_valid_i) begin
          state_d    = S_RESP;
          rsp_data_d = w_ext;
          rsp_err_d  = 1'b0;
        end else if (w_timeout) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register only, so an asynchronous reset
  // drops periph_req_o and busy_o immediately.
  always_comb begin
    req_ready_o  = 1'b0;
    periph_req_o = 1'b0;
    rsp_valid_o  = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      S_PERIPH_WAIT: periph_req_o = 1'b1;
      S_RESP:        rsp_valid_o  = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_err_o  = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_rdata_merge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_rdata_merge
//  Purpose  : Self-checking bench for lsu_rdata_merge: directed load cases,
//             randomized loads against a reference model, and an
//             asynchronous reset in the middle of a peripheral wait.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_rdata_merge;

  localparam int ADDR_W = 12;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic [1:0]        req_sel_i = '0;
  logic [2:0]        req_funct3_i = '0;
  logic [31:0]       mem_rdata_i = '0;
  logic              periph_req_o;
  logic [31:0]       periph_rdata_i = '0;
  logic              periph_valid_i = 1'b0;
  logic              rsp_valid_o;
  logic [31:0]       rsp_data_o;
  logic              rsp_err_o;
  logic              busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_rdata_merge #(.ADDR_W(ADDR_W), .PERIPH_TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_sel_i      (req_sel_i),
    .req_funct3_i   (req_funct3_i),
    .mem_rdata_i    (mem_rdata_i),
    .periph_req_o   (periph_req_o),
    .periph_rdata_i (periph_rdata_i),
    .periph_valid_i (periph_valid_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_err_o      (rsp_err_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: {err, data} for a request, judged only on the request itself.
  function automatic logic [32:0] model_rsp(input logic [ADDR_W-1:0] addr,
                                            input logic [2:0] f3,
                                            input logic [1:0] sel,
                                            input logic [31:0] w);
    int unsigned off;
    logic [31:0] b, h, d;
    logic e;
    off = addr % 4;
    e = (f3 == 3) || (f3 == 6) || (f3 == 7)
        || (((f3 == 1) || (f3 == 5)) && (off % 2 == 1))
        || ((f3 == 2) && (off != 0))
        || (sel == 3);
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    d = 32'h0;
    if (!e) begin
      case (f3)
        3'd0:    d = (b >= 128) ? b + 32'hFFFFFF00 : b;
        3'd4:    d = b;
        3'd1:    d = (h >= 32768) ? h + 32'hFFFF0000 : h;
        3'd5:    d = h;
        default: d = w;
      endcase
    end
    return {e, d};
  endfunction

  // One complete transaction. pdly = accept-relative cycle at which the
  // peripheral valid is sampled (1 = first wait cycle); 0 = never.
  task automatic run_txn(input string name, input logic [ADDR_W-1:0] addr,
                         input logic [2:0] f3, input logic [1:0] sel,
                         input logic [31:0] word, input int pdly);
    logic [32:0] r;
    logic        exp_err;
    logic [31:0] exp_data, got_data;
    logic        got_err;
    int exp_lat, exp_preq, rsp_at, pulses, preq_cnt;
    r        = model_rsp(addr, f3, sel, word);
    exp_err  = r[32];
    exp_data = r[31:0];
    if (exp_err) begin
      exp_lat = 0; exp_preq = 0;
    end else if (sel != 2'b10) begin
      exp_lat = 1; exp_preq = 0;
    end else if (pdly >= 1 && pdly <= TO) begin
      exp_lat = pdly; exp_preq = pdly;
    end else begin
      exp_err = 1'b1; exp_data = 32'h0; exp_lat = TO; exp_preq = TO;
    end

    @(posedge clk); #1;
    chk({name, ".ready"}, {31'h0, req_ready_o}, 32'h1);
    req_valid_i  = 1'b1;
    req_addr_i   = addr;
    req_funct3_i = f3;
    req_sel_i    = sel;
    @(posedge clk); #1;          // accept edge
    req_valid_i  = 1'b0;
    req_addr_i   = ADDR_W'($urandom);
    req_funct3_i = 3'($urandom);
    req_sel_i    = 2'($urandom);
    rsp_at = -1; pulses = 0; preq_cnt = 0;
    got_data = '0; got_err = 1'b0;
    for (int j = 0; j < 40; j++) begin
      mem_rdata_i = (j == 0) ? word : $urandom;
      if (sel == 2'b10) begin
        periph_valid_i = (pdly != 0) && (j == pdly - 1);
        periph_rdata_i = ((pdly != 0) && (j == pdly - 1)) ? word : $urandom;
      end else begin
        periph_valid_i = 1'($urandom);
        periph_rdata_i = $urandom;
      end
      @(negedge clk);
      if (periph_req_o) preq_cnt++;
      if (rsp_valid_o) begin
        pulses++;
        if (rsp_at < 0) begin
          rsp_at   = j;
          got_data = rsp_data_o;
          got_err  = rsp_err_o;
        end
      end
      if (j == 0) begin
        chk({name, ".busy"},   {31'h0, busy_o},      32'h1);
        chk({name, ".nready"}, {31'h0, req_ready_o}, 32'h0);
      end
      if (rsp_at >= 0 && j == rsp_at + 1) begin
        chk({name, ".idle"}, {30'h0, busy_o, rsp_valid_o}, 32'h0);
        chk({name, ".hold"}, rsp_data_o, got_data);
        break;
      end
      @(posedge clk); #1;
    end
    periph_valid_i = 1'b0;
    chk({name, ".lat"},    32'(rsp_at),   32'(exp_lat));
    chk({name, ".pulses"}, 32'(pulses),   32'h1);
    chk({name, ".data"},   got_data,      exp_data);
    chk({name, ".err"},    {31'h0, got_err}, {31'h0, exp_err});
    chk({name, ".preq"},   32'(preq_cnt), 32'(exp_preq));
  endtask

  logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [2:0]        rf;
    int                seen, preq_seen;

    // Reset state
    #2;
    chk("reset.ready", {31'h0, req_ready_o}, 32'h1);
    chk("reset.outs", {29'h0, periph_req_o, rsp_valid_o, busy_o}, 32'h0);
    chk("reset.data", rsp_data_o, 32'h0);
    chk("reset.err", {31'h0, rsp_err_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases
    run_txn("mem_lw",   12'h104, 3'b010, 2'b01, 32'hDEADBEEF, 0);
    run_txn("lb_off3",  12'h103, 3'b000, 2'b00, 32'h80FF7F01, 0);
    run_txn("lbu_off3", 12'h103, 3'b100, 2'b00, 32'h80FF7F01, 0);
    run_txn("lh_off2",  12'h102, 3'b001, 2'b01, 32'h80FF7F01, 0);
    run_txn("lhu_off0", 12'h100, 3'b101, 2'b00, 32'h80FF7F01, 0);
    run_txn("lb_off1",  12'h101, 3'b000, 2'b01, 32'h80FF7F01, 0);
    run_txn("per_wait", 12'h300, 3'b010, 2'b10, 32'h12345678, 5);
    run_txn("per_to",   12'h300, 3'b010, 2'b10, 32'h12345678, 0);
    run_txn("per_last", 12'h304, 3'b010, 2'b10, 32'hCAFEF00D, TO);
    run_txn("per_lb",   12'h302, 3'b000, 2'b10, 32'h00A50000, 1);
    run_txn("err_lw",   12'h102, 3'b010, 2'b01, 32'h11111111, 0);
    run_txn("err_f3",   12'h100, 3'b011, 2'b00, 32'h22222222, 0);
    run_txn("err_sel",  12'h100, 3'b010, 2'b11, 32'h33333333, 0);
    run_txn("err_lh",   12'h101, 3'b001, 2'b01, 32'h44444444, 0);
    run_txn("err_per",  12'h101, 3'b010, 2'b10, 32'h55555555, 1);

    // Reset in the middle of a peripheral wait
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_addr_i = 12'h200; req_funct3_i = 3'b010; req_sel_i = 2'b10;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_mid.pre_preq", {31'h0, periph_req_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid.preq", {31'h0, periph_req_o}, 32'h0);
    chk("rst_mid.busy", {31'h0, busy_o}, 32'h0);
    chk("rst_mid.rsp",  {31'h0, rsp_valid_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0; preq_seen = 0;
    for (int j = 0; j < 20; j++) begin
      periph_valid_i = 1'b1;
      periph_rdata_i = $urandom;
      @(negedge clk);
      if (rsp_valid_o) seen++;
      if (periph_req_o) preq_seen++;
      @(posedge clk); #1;
    end
    periph_valid_i = 1'b0;
    chk("rst_mid.no_rsp",  32'(seen), 32'h0);
    chk("rst_mid.no_preq", 32'(preq_seen), 32'h0);
    run_txn("post_rst", 12'h104, 3'b010, 2'b01, 32'hA5A55A5A, 0);

    // Randomized loads
    for (int i = 0; i < 60; i++) begin
      ra = ADDR_W'($urandom);
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) rf = 3'($urandom);
      else                           rf = legal[$urandom_range(0, 4)];
      run_txn($sformatf("rnd%0d", i), ra, rf, 2'($urandom), $urandom,
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_rdata_merge.md
Name: lsu_rdata_merge

Overview:
- Return path of the LSU address split. It accepts one load request at a time.
- It collects read data from data memory (fixed 1-cycle latency) or from the peripheral bus (variable latency, valid-qualified).
- It aligns and extends the selected byte, half or word per the load type, and returns a single response pulse to the LSU.
- It uses the same address-select encoding as the address split: 2'b00/2'b01 = memory, 2'b10 = peripheral, 2'b11 = unmapped.

Parameters:
- ADDR_W, 12, request address width.
- PERIPH_TIMEOUT, 16, maximum cycles to wait for periph_valid_i before returning an error. 0 disables the timeout.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_valid_i  input  1  load request valid.
- req_ready_o  output  1  block can accept a request.
- req_addr_i  input  ADDR_W  load byte address.
- req_sel_i  input  2  address select, same encoding as the address split.
- req_funct3_i  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_rdata_i  input  32  memory read word, valid one cycle after the request is accepted.
- periph_req_o  output  1  peripheral read request, held until the response or timeout.
- periph_rdata_i  input  32  peripheral read word.
- periph_valid_i  input  1  periph_rdata_i valid this cycle.
- rsp_valid_o  output  1  one-cycle response pulse.
- rsp_data_o  output  32  aligned, extended load data.
- rsp_err_o  output  1  response is an error (misaligned, illegal funct3, unmapped, timeout).
- busy_o  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - FSM goes to IDLE; timeout counter clears; captured offset, funct3 and sel clear.
  - Outputs: req_ready_o=1, periph_req_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0.
  - Reset mid-transaction abandons the transaction silently: no response is issued and periph_req_o drops immediately.
- States: IDLE, MEM_WAIT, PERIPH_WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture addr[1:0], funct3 and sel.
  - Error check, in priority order: illegal funct3 (011, 110, 111), then misalignment (LH/LHU with addr[0]=1; LW with addr[1:0]!=0), then sel=2'b11.
    - Any error: go to RESP with err=1, data=0. No memory or peripheral access; periph_req_o is never raised.
    - No error, sel 00/01: go to MEM_WAIT.
    - No error, sel 10: go to PERIPH_WAIT.
- MEM_WAIT (exactly one cycle): capture mem_rdata_i, go to RESP.
- PERIPH_WAIT:
  - periph_req_o=1; the counter increments each cycle.
  - periph_valid_i=1: capture periph_rdata_i, go to RESP.
  - Otherwise, if PERIPH_TIMEOUT!=0 and counter==PERIPH_TIMEOUT-1: go to RESP with err=1, data=0.
  - periph_valid_i wins over a timeout in the same cycle.
  - periph_valid_i outside PERIPH_WAIT is ignored.
- RESP:
  - rsp_valid_o=1 for exactly one cycle; rsp_data_o and rsp_err_o are registered and stable during the pulse.
  - Always returns to IDLE; the LSU never back-pressures the response.
  - req_ready_o=0, so a new request is accepted in the cycle after RESP at the earliest.
- Outside RESP, rsp_valid_o=0. rsp_data_o and rsp_err_o hold their last values.
- Latency, with the request accepted in cycle T:
  - Memory: sample at T+1, rsp_valid_o at T+2.
  - Peripheral: valid at cycle V, rsp_valid_o at V+1.
  - Error at accept: rsp_valid_o at T+1.
- Throughput: one request per 2 to 3+ cycles; no pipelining.
- Extraction from the captured word W with offset o=addr[1:0]:
  - LB: sign-extend W[8o+7:8o].
  - LBU: zero-extend W[8o+7:8o].
  - LH: sign-extend W[16·o[1]+15:16·o[1]].
  - LHU: zero-extend W[16·o[1]+15:16·o[1]].
  - LW: W.
- busy_o = (state != IDLE).

Test Plan:
- Memory LW: addr=0x104, sel=01, funct3=010, mem_rdata_i=0xDEADBEEF at T+1 -> rsp_valid_o at T+2 only, rsp_data_o=0xDEADBEEF, rsp_err_o=0, periph_req_o=0 throughout.
- Memory byte/half extension: W=0x80FF7F01.
  - LB off 3 -> 0xFFFFFF80.
  - LBU off 3 -> 0x00000080.
  - LH off 2 -> 0xFFFF80FF.
  - LHU off 0 -> 0x00007F01.
  - LB off 1 -> 0x0000007F.
- Peripheral with wait: sel=10, LW, periph_valid_i raised 5 cycles after accept with 0x12345678 -> periph_req_o high for 5 cycles then low, rsp_valid_o one cycle later, data 0x12345678, err 0.
- Peripheral timeout: sel=10, PERIPH_TIMEOUT=16, no periph_valid_i -> periph_req_o high 16 cycles, then rsp_valid_o with err=1, data=0.
  - Repeat with periph_valid_i in the 16th cycle -> data returned, err=0.
- Errors:
  - LW at addr 0x102 -> err=1, data=0, rsp at T+1, no access.
  - funct3=011 -> err=1.
  - sel=11 -> err=1.
  - LH at addr 0x101 -> err=1.
- Reset mid-operation: assert rst_i during PERIPH_WAIT, asynchronously between edges -> periph_req_o and busy_o drop immediately, no rsp_valid_o ever for that request; the next memory LW completes normally.
